rails_source: RTL and testbench

Stimulus-and-check engine for the `rails` station checker. It generates one train departure order per frame on `data1` using a simulated station (LIFO) driven by an LFSR, so that order is always achievable. On `data2` it sends either the same order or a deliberately unreachable order. It drives `number`, `data1` and `data2` in the frame format `rails` consumes, waits for `valid`, and scores `result1`/`result2` against internally known expectations.

---
 rtl/rails_source.sv | 207 ++++++++++++++++++++
 tb/tb_rails_source.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rails_source.sv
// rails_source: stimulus-and-check engine for the rails station checker.
// Each frame builds a stack-reachable departure order with an LFSR-driven
// station model, sends it as number/data1/data2, optionally sends an
// unreachable order on data2, then scores the checker's valid/result response.
module rails_source #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          MAX_N   = 10,
  parameter int          TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cfg_n,
  input  logic       corrupt,
  output logic [3:0] number,
  output logic [3:0] data1,
  output logic [3:0] data2,
  output logic       frame,
  input  logic       rsp_valid,
  input  logic       rsp_result1,
  input  logic       rsp_result2,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic       timeout,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]   SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]    MAX_N4     = 4'(MAX_N);
  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CW = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SEND_NUM,
    S_SEND_DATA,
    S_WAIT
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [3:0]    n_q;
  logic          corrupt_q;
  logic [4:0]    next_in;    // next train to enter the station, reaches N+1
  logic [3:0]    sp;         // stack depth
  logic [3:0]    wp;         // departure buffer write pointer
  logic [3:0]    idx;        // SEND_DATA index
  logic [CW-1:0] wait_cnt;

  logic [3:0] stack_mem [MAX_N];
  logic [3:0] buf_mem   [MAX_N];

  logic [3:0]  n_clamped;
  logic        do_pop;
  logic [15:0] lfsr_next;
  logic [3:0]  sp_dec;
  logic [3:0]  wp_inc;
  logic [3:0]  idx_inc;
  logic        exp2;
  logic        rsp_ok;

  // Clamp the requested train count into 1..MAX_N.
  // NOTE: the default assignment comes first so every path drives n_clamped and no latch is inferred.
  always_comb begin
    n_clamped = cfg_n;
    if (cfg_n == 4'd0) begin
      n_clamped = 4'd1;
    end else if (cfg_n > MAX_N4) begin
      n_clamped = MAX_N4;
    end
  end

  // Station step decision: forced push when empty, forced pop once all trains entered.
  assign do_pop    = (sp != 4'd0) && ((next_in > {1'b0, n_q}) || lfsr[0]);
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign sp_dec    = sp - 4'd1;
  assign wp_inc    = wp + 4'd1;
  assign idx_inc   = idx + 4'd1;
  // data2 is unreachable only when the rotated order N,1,2,.. has N >= 3.
  assign exp2      = !(corrupt_q && (n_q >= 4'd3));
  assign rsp_ok    = rsp_result1 && (rsp_result2 == exp2);

  // Station storage: stack push/pop and departure buffer capture during GEN.
  // NOTE: these arrays have no reset; sp, wp and next_in are reset and every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (state == S_GEN) begin
      if (do_pop) begin
        buf_mem[wp] <= stack_mem[sp_dec];
      end else begin
        stack_mem[sp] <= next_in[3:0];
      end
    end
  end

  // Frame sequencer with registered outputs and scoring.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      n_q       <= 4'd0;
      corrupt_q <= 1'b0;
      next_in   <= 5'd0;
      sp        <= 4'd0;
      wp        <= 4'd0;
      idx       <= 4'd0;
      wait_cnt  <= '0;
      number    <= 4'd0;
      data1     <= 4'd0;
      data2     <= 4'd0;
      frame     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
      pass_cnt  <= 8'd0;
      fail_cnt  <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q       <= n_clamped;
            corrupt_q <= corrupt;
            mismatch  <= 1'b0;
            timeout   <= 1'b0;
            next_in   <= 5'd1;
            sp        <= 4'd0;
            wp        <= 4'd0;
            busy      <= 1'b1;
            state     <= S_GEN;
          end
        end

        S_GEN: begin
          lfsr <= lfsr_next;
          if (do_pop) begin
            sp <= sp_dec;
            wp <= wp_inc;
            if (wp_inc == n_q) begin
              number <= n_q;
              frame  <= 1'b1;
              state  <= S_SEND_NUM;
            end
          end else begin
            sp      <= sp + 4'd1;
            next_in <= next_in + 5'd1;
          end
        end

        S_SEND_NUM: begin
          number <= 4'd0;
          data1  <= buf_mem[4'd0];
          data2  <= corrupt_q ? n_q : buf_mem[4'd0];
          idx    <= 4'd0;
          state  <= S_SEND_DATA;
        end

        S_SEND_DATA: begin
          if (idx_inc == n_q) begin
            data1    <= 4'd0;
            data2    <= 4'd0;
            frame    <= 1'b0;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            data1 <= buf_mem[idx_inc];
            data2 <= corrupt_q ? idx_inc : buf_mem[idx_inc];
            idx   <= idx_inc;
          end
        end

        S_WAIT: begin
          if (rsp_valid) begin
            if (rsp_ok) begin
              pass_cnt <= (pass_cnt == 8'hFF) ? pass_cnt : pass_cnt + 8'd1;
            end else begin
              fail_cnt <= (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
              mismatch <= 1'b1;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (wait_cnt == TIMEOUT_CW) begin
            fail_cnt <= (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
            mismatch <= 1'b1;
            timeout  <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rails_source.sv
// Testbench for rails_source: a generator model fills expected number/data
// queues at each start, a negedge monitor pops and compares DUT output,
// and the driver checks latency, scoring, timeout and reset behaviour.
module tb_rails_source;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          MAX_N = 10;
  localparam int          TOUT  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cfg_n = 4'd0;
  logic       corrupt = 1'b0;
  logic       rsp_valid = 1'b0;
  logic       rsp_result1 = 1'b0;
  logic       rsp_result2 = 1'b0;
  logic [3:0] number, data1, data2;
  logic       frame, busy, done, mismatch, timeout;
  logic [7:0] pass_cnt, fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  int exp_num_q[$];
  int exp_d1_q[$];
  int exp_d2_q[$];
  int act_q[$];
  int ref_q[$];

  logic [15:0] m_lfsr = SEED;
  int exp_pass = 0;
  int exp_fail = 0;
  int last_n = 0;
  bit last_corr = 1'b0;

  rails_source #(.SEED(SEED), .MAX_N(MAX_N), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_n(cfg_n), .corrupt(corrupt),
    .number(number), .data1(data1), .data2(data2), .frame(frame),
    .rsp_valid(rsp_valid), .rsp_result1(rsp_result1), .rsp_result2(rsp_result2),
    .busy(busy), .done(done), .mismatch(mismatch), .timeout(timeout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Drive point: 2 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic int clamp_n(input logic [3:0] c);
    if (c == 4'd0) return 1;
    if (int'(c) > MAX_N) return MAX_N;
    return int'(c);
  endfunction

  // Reference station: pushes 1..n, pops per the LFSR, one LFSR shift per step.
  task automatic gen_expected(input int n, input bit corr);
    logic [15:0] l;
    int nxt;
    int stk[$];
    int out[$];
    bit take;
    l = m_lfsr;
    nxt = 1;
    while (out.size() < n) begin
      if (stk.size() == 0) take = 1'b0;
      else if (nxt > n) take = 1'b1;
      else take = l[0];
      if (take) out.push_back(stk.pop_back());
      else begin
        stk.push_back(nxt);
        nxt++;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    m_lfsr = l;
    exp_num_q.push_back(n);
    for (int k = 0; k < n; k++) begin
      exp_d1_q.push_back(out[k]);
      exp_d2_q.push_back(corr ? ((k == 0) ? n : k) : out[k]);
    end
  endtask

  // Independent reachability test: greedy stack replay of a departure order.
  function automatic bit reachable(input int ord[$], input int n);
    int stk[$];
    int nxt;
    nxt = 1;
    if (ord.size() != n) return 1'b0;
    foreach (ord[i]) begin
      if (ord[i] < 1 || ord[i] > n) return 1'b0;
      while (nxt <= ord[i]) begin
        stk.push_back(nxt);
        nxt++;
      end
      if (stk.size() == 0 || stk[$] != ord[i]) return 1'b0;
      void'(stk.pop_back());
    end
    return 1'b1;
  endfunction

  // Scoreboard monitor: compare emitted number/data against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame && number != 4'd0) begin
        if (exp_num_q.size() == 0) check("extra_number", 32'(number), 0);
        else check("number", 32'(number), exp_num_q.pop_front());
      end else if (frame) begin
        act_q.push_back(int'(data1));
        if (exp_d1_q.size() == 0) check("extra_data", 32'(frame), 0);
        else begin
          check("data1", 32'(data1), exp_d1_q.pop_front());
          check("data2", 32'(data2), exp_d2_q.pop_front());
        end
      end else if ({number, data1, data2} != 12'd0) begin
        check("idle_out", 32'({number, data1, data2}), 0);
      end
    end
  end

  task automatic flush_model();
    exp_num_q.delete();
    exp_d1_q.delete();
    exp_d2_q.delete();
    act_q.delete();
    m_lfsr = SEED;
    exp_pass = 0;
    exp_fail = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    flush_model();
  endtask

  // Start a frame and follow it to WAIT entry; optionally poke start in SEND_DATA.
  task automatic run_frame(input logic [3:0] cfg, input bit corr, input bit poke_start);
    int n;
    int cnt;
    n = clamp_n(cfg);
    last_n = n;
    last_corr = corr;
    gen_expected(n, corr);
    act_q.delete();
    cfg_n = cfg;
    corrupt = corr;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cfg_n = 4'd0;
    corrupt = 1'b0;
    check("busy_start", 32'(busy), 1);
    cnt = 1;
    while (number == 4'd0 && cnt < 200) begin
      cyc();
      cnt++;
    end
    // Edges after the start-sampling edge until number is visible.
    check("num_latency", cnt - 1, 2 * n);
    if (poke_start) begin
      cyc();
      start = 1'b1;
      cfg_n = 4'd7;
      cyc();
      start = 1'b0;
      cfg_n = 4'd0;
    end
    cnt = 0;
    while (frame && cnt < 100) begin
      cyc();
      cnt++;
    end
    if (frame) check("frame_end", 32'(frame), 0);
  endtask

  task automatic respond(input bit r1, input bit r2);
    bit ok;
    ok = r1 && (r2 == !(last_corr && last_n >= 3));
    rsp_valid = 1'b1;
    rsp_result1 = r1;
    rsp_result2 = r2;
    cyc();
    rsp_valid = 1'b0;
    rsp_result1 = 1'b0;
    rsp_result2 = 1'b0;
    if (ok) exp_pass++;
    else exp_fail++;
    check("done", 32'(done), 1);
    check("pass_cnt", 32'(pass_cnt), exp_pass);
    check("fail_cnt", 32'(fail_cnt), exp_fail);
    check("mismatch", 32'(mismatch), 32'(!ok));
    check("timeout_flag", 32'(timeout), 0);
    cyc();
    check("done_pulse", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // Reset state.
    repeat (3) cyc();
    reset = 1'b0;
    check("rst_bus", 32'({number, data1, data2}), 0);
    check("rst_ctl", 32'({frame, busy, done, mismatch, timeout}), 0);
    check("rst_pass", 32'(pass_cnt), 0);
    check("rst_fail", 32'(fail_cnt), 0);

    // Response outside WAIT is ignored.
    rsp_valid = 1'b1;
    rsp_result1 = 1'b1;
    rsp_result2 = 1'b1;
    cyc();
    rsp_valid = 1'b0;
    rsp_result1 = 1'b0;
    rsp_result2 = 1'b0;
    cyc();
    check("idle_rsp_done", 32'(done), 0);
    check("idle_rsp_pass", 32'(pass_cnt), 0);

    // N=1 corrupt: data2 = 1, reachable, pass.
    run_frame(4'd1, 1'b1, 1'b0);
    respond(1'b1, 1'b1);
    // N=3 corrupt: data2 = 3,1,2 unreachable.
    run_frame(4'd3, 1'b1, 1'b0);
    respond(1'b1, 1'b0);
    run_frame(4'd3, 1'b1, 1'b0);
    respond(1'b1, 1'b1);
    // Clamping: 0 -> 1, 15 -> MAX_N.
    run_frame(4'd0, 1'b0, 1'b0);
    respond(1'b1, 1'b1);
    run_frame(4'd15, 1'b0, 1'b0);
    respond(1'b1, 1'b1);

    // Fifty full-size frames with independent reachability checking.
    for (int f = 0; f < 50; f++) begin
      run_frame(4'd10, 1'b0, 1'b0);
      check("reachable", 32'(reachable(act_q, 10)), 1);
      respond(1'b1, 1'b1);
    end

    // Timeout with a start pulse ignored during SEND_DATA.
    run_frame(4'd4, 1'b0, 1'b1);
    cnt = 0;
    while (!done && cnt < TOUT + 20) begin
      cyc();
      cnt++;
    end
    exp_fail++;
    check("wait_cycles", cnt, TOUT + 1);
    check("to_timeout", 32'(timeout), 1);
    check("to_mismatch", 32'(mismatch), 1);
    check("to_fail_cnt", 32'(fail_cnt), exp_fail);
    check("to_pass_cnt", 32'(pass_cnt), exp_pass);
    cyc();
    check("to_done_pulse", 32'(done), 0);
    check("to_busy", 32'(busy), 0);

    // Reference order straight after reset.
    do_reset();
    run_frame(4'd5, 1'b0, 1'b0);
    ref_q = act_q;
    respond(1'b1, 1'b1);

    // Abort a frame in SEND_DATA.
    gen_expected(5, 1'b0);
    act_q.delete();
    cfg_n = 4'd5;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cfg_n = 4'd0;
    cnt = 0;
    while (number == 4'd0 && cnt < 100) begin
      cyc();
      cnt++;
    end
    cyc();
    cyc();
    check("abort_in_frame", 32'(frame), 1);
    reset = 1'b1;
    cyc();
    check("abort_bus", 32'({number, data1, data2}), 0);
    check("abort_ctl", 32'({frame, busy, done, mismatch, timeout}), 0);
    check("abort_pass", 32'(pass_cnt), 0);
    check("abort_fail", 32'(fail_cnt), 0);
    reset = 1'b0;
    flush_model();

    // Same cfg after reset reproduces the reference order.
    run_frame(4'd5, 1'b0, 1'b0);
    check("repro_len", act_q.size(), ref_q.size());
    for (int k = 0; k < act_q.size() && k < ref_q.size(); k++) begin
      check("repro", act_q[k], ref_q[k]);
    end
    respond(1'b1, 1'b1);

    check("sb_empty", exp_num_q.size() + exp_d1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
